// File: rtl/medidor_ultrassonico.sv
// medidor_ultrassonico: HC-SR04 trigger/echo timer producing distance in cm without a divider.
// Define MEDIDOR_MEDIA_EN to output the average of the last four results instead of the raw one.
module medidor_ultrassonico #(
   parameter int TICKS_US   = 50,
   parameter int TRIG_US    = 10,
   parameter int TIMEOUT_US = 30000,
   parameter int PERIOD_US  = 60000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       echo,
   output logic       trigger,
   output logic [7:0] distancia_cm,
   output logic       valido,
   output logic       erro,
   output logic       ocupado
);
   localparam int PW = $clog2(TICKS_US + 1);
   localparam int TW = $clog2(TIMEOUT_US + TRIG_US + 1);
   localparam int NW = $clog2(PERIOD_US + 1);
   localparam logic [PW-1:0] PRE_MAX  = PW'(TICKS_US - 1);
   localparam logic [TW-1:0] TRIG_MAX = TW'(TRIG_US - 1);
   localparam logic [TW-1:0] TOUT_MAX = TW'(TIMEOUT_US - 1);
   localparam logic [NW-1:0] PER_MAX  = NW'(PERIOD_US - 1);
   localparam logic [NW-1:0] PER_SAT  = NW'(PERIOD_US);

   typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, DONE} state_t;

   state_t          state_q, state_d;
   logic [2:0]      sync_q, sync_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [PW-1:0]   ppre_q, ppre_d;
   logic [NW-1:0]   per_q, per_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [5:0]      sub_q, sub_d;
   logic [7:0]      cm_q, cm_d;
   logic            trigger_q, trigger_d;
   logic            erro_q, erro_d;
   logic            us_tick, per_tick, rise, fall, start, fin, tout;
   logic [7:0]      res;
`ifdef MEDIDOR_MEDIA_EN
   logic [3:0][7:0] buf_q, buf_d;
   logic [9:0]      sum_q, sum_d;
`else
   logic [7:0]      dist_q, dist_d;
`endif

   assign rise = sync_q[1] & ~sync_q[2];
   assign fall = ~sync_q[1] & sync_q[2];

   always_comb begin
      sync_d    = {sync_q[1:0], echo};
      state_d   = state_q;
      trigger_d = trigger_q;
      us_tick   = presc_q == PRE_MAX;
      presc_d   = us_tick ? '0 : presc_q + PW'(1);
      tmr_d     = us_tick ? tmr_q + TW'(1) : tmr_q;
      per_tick  = ppre_q == PRE_MAX;
      ppre_d    = per_tick ? '0 : ppre_q + PW'(1);
      per_d     = (per_tick && per_q != PER_SAT) ? per_q + NW'(1) : per_q;
      sub_d     = sub_q;
      cm_d      = cm_q;
      fin       = 1'b0;
      tout      = 1'b0;
      start     = (state_q == TRIG && !trigger_q) ||
                  (state_q == IDLE && ((per_tick && per_q == PER_MAX) || per_q == PER_SAT));
      case (state_q)
         TRIG: begin
            if (trigger_q && us_tick && tmr_q == TRIG_MAX) begin
               trigger_d = 1'b0;
               tmr_d     = '0;
               state_d   = WAIT_ECHO;
            end
         end
         WAIT_ECHO: begin
            if (rise) begin
               state_d = MEASURE;
               presc_d = '0;
               sub_d   = '0;
               cm_d    = '0;
               tmr_d   = '0;
            end else if (us_tick && tmr_q == TOUT_MAX) begin
               state_d = DONE;
               fin     = 1'b1;
               tout    = 1'b1;
            end
         end
         MEASURE: begin
            // 58 us of round trip per cm; the tick in the fall cycle still counts
            if (us_tick) begin
               sub_d = (sub_q == 6'd57) ? 6'd0 : sub_q + 6'd1;
               cm_d  = (sub_q == 6'd57 && cm_q != 8'd255) ? cm_q + 8'd1 : cm_q;
            end
            if (fall) begin
               state_d = DONE;
               fin     = 1'b1;
            end else if (us_tick && tmr_q == TOUT_MAX) begin
               state_d = DONE;
               fin     = 1'b1;
               tout    = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = state_q;
      endcase
      // the period prescaler restarts with each trigger so measurements stay exactly PERIOD_US apart
      if (start) begin
         state_d   = TRIG;
         trigger_d = 1'b1;
         presc_d   = '0;
         tmr_d     = '0;
         ppre_d    = '0;
         per_d     = '0;
      end
      res    = tout ? 8'd255 : cm_d;
      erro_d = fin ? tout : erro_q;
`ifdef MEDIDOR_MEDIA_EN
      buf_d = fin ? {buf_q[2:0], res} : buf_q;
      sum_d = fin ? sum_q - {2'b00, buf_q[3]} + {2'b00, res} : sum_q;
`else
      dist_d = fin ? res : dist_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= TRIG;
         sync_q    <= '0;
         presc_q   <= '0;
         ppre_q    <= '0;
         per_q     <= '0;
         tmr_q     <= '0;
         sub_q     <= '0;
         cm_q      <= '0;
         trigger_q <= 1'b0;
         erro_q    <= 1'b0;
`ifdef MEDIDOR_MEDIA_EN
         buf_q     <= '0;
         sum_q     <= '0;
`else
         dist_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         presc_q   <= presc_d;
         ppre_q    <= ppre_d;
         per_q     <= per_d;
         tmr_q     <= tmr_d;
         sub_q     <= sub_d;
         cm_q      <= cm_d;
         trigger_q <= trigger_d;
         erro_q    <= erro_d;
`ifdef MEDIDOR_MEDIA_EN
         buf_q     <= buf_d;
         sum_q     <= sum_d;
`else
         dist_q    <= dist_d;
`endif
      end
   end

`ifdef MEDIDOR_MEDIA_EN
   assign distancia_cm = sum_q[9:2];
`else
   assign distancia_cm = dist_q;
`endif
   assign trigger = trigger_q;
   assign valido  = state_q == DONE;
   assign erro    = erro_q;
   assign ocupado = trigger_q || state_q == WAIT_ECHO || state_q == MEASURE;
endmodule

// File: tb/tb_medidor_ultrassonico.sv
// tb_medidor_ultrassonico: directed tests of the ultrasonic ranging front-end.
// Scaled timing: 2 ticks/us, 10 us trigger, 15000 us timeout, 15500 us period.
module tb_medidor_ultrassonico;
   localparam int TK = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       echo = 1'b0;
   logic       trigger, valido, erro, ocupado;
   logic [7:0] distancia_cm;
   int         runs = 0;
   int         fails = 0;

   always #5 clk = ~clk;

   medidor_ultrassonico #(
      .TICKS_US(TK), .TRIG_US(10), .TIMEOUT_US(15000), .PERIOD_US(15500)
   ) dut (
      .clk(clk), .rst_n(rst_n), .echo(echo), .trigger(trigger),
      .distancia_cm(distancia_cm), .valido(valido), .erro(erro), .ocupado(ocupado)
   );

   function automatic logic [7:0] exp_d(input int r);
`ifdef MEDIDOR_MEDIA_EN
      return 8'(r >> 2);
`else
      return 8'(r);
`endif
   endfunction

   task automatic do_reset(input logic e);
      echo  = e;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_fall(input int lim, output bit ok);
      for (int i = 0; i < lim && trigger !== 1'b1; i++) @(negedge clk);
      ok = trigger === 1'b1;
      for (int i = 0; i < 100 && trigger !== 1'b0; i++) @(negedge clk);
      ok = ok && trigger === 1'b0;
   endtask

   task automatic wait_valido(input int lim, output int n);
      n = 0;
      while (valido !== 1'b1 && n < lim) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic pulse(input int cyc);
      echo = 1'b1;
      repeat (cyc) @(negedge clk);
      echo = 1'b0;
   endtask

   task automatic test_reset;
      int n;
      echo  = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      runs++; if ({trigger, valido, erro, ocupado} !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b want 0000", {trigger, valido, erro, ocupado}); end
      runs++; if (distancia_cm !== 8'd0) begin fails++; $display("FAIL reset_dist got %0d want 0", distancia_cm); end
      rst_n = 1'b1;
      @(negedge clk);
      runs++; if (trigger !== 1'b1) begin fails++; $display("FAIL trig_first_edge got %b want 1", trigger); end
      runs++; if (ocupado !== 1'b1) begin fails++; $display("FAIL ocupado_trig got %b want 1", ocupado); end
      n = 0;
      while (trigger === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      runs++; if (n != 10 * TK) begin fails++; $display("FAIL trig_width got %0d want %0d", n, 10 * TK); end
      repeat (50) @(negedge clk);
      runs++; if ({valido, erro, ocupado} !== 3'b001) begin fails++; $display("FAIL wait_flags got %b want 001", {valido, erro, ocupado}); end
      runs++; if (distancia_cm !== 8'd0) begin fails++; $display("FAIL wait_dist got %0d want 0", distancia_cm); end
   endtask

   task automatic test_distance(input int us, input int cm, input string name);
      bit ok;
      int n;
      do_reset(1'b0);
      wait_fall(100, ok);
      runs++; if (!ok) begin fails++; $display("FAIL %s_trigger got no trigger pulse want one", name); end
      repeat (10) @(negedge clk);
      pulse(us * TK);
      wait_valido(20, n);
      runs++; if (valido !== 1'b1 || n != 3) begin fails++; $display("FAIL %s_valido got %b after %0d want 1 after 3", name, valido, n); end
      runs++; if (distancia_cm !== exp_d(cm)) begin fails++; $display("FAIL %s_dist got %0d want %0d", name, distancia_cm, exp_d(cm)); end
      runs++; if (erro !== 1'b0) begin fails++; $display("FAIL %s_erro got %b want 0", name, erro); end
      @(negedge clk);
      runs++; if ({valido, ocupado} !== 2'b00) begin fails++; $display("FAIL %s_after got %b want 00", name, {valido, ocupado}); end
      runs++; if (distancia_cm !== exp_d(cm)) begin fails++; $display("FAIL %s_hold got %0d want %0d", name, distancia_cm, exp_d(cm)); end
   endtask

   task automatic test_timeout;
      int n;
      do_reset(1'b0);
      @(negedge clk);
      n = 0;
      while (valido !== 1'b1 && n < 40000) begin
         @(negedge clk);
         n++;
      end
      runs++; if (n != 30020) begin fails++; $display("FAIL tout_valido_at got %0d want 30020", n); end
      runs++; if (distancia_cm !== exp_d(255)) begin fails++; $display("FAIL tout_dist got %0d want %0d", distancia_cm, exp_d(255)); end
      runs++; if (erro !== 1'b1) begin fails++; $display("FAIL tout_erro got %b want 1", erro); end
      while (trigger !== 1'b1 && n < 40000) begin
         @(negedge clk);
         n++;
      end
      runs++; if (n != 31000) begin fails++; $display("FAIL tout_next_trig got %0d want 31000", n); end
      runs++; if (erro !== 1'b1) begin fails++; $display("FAIL tout_erro_held got %b want 1", erro); end
   endtask

   task automatic test_reset_mid_measure;
      bit ok;
      bit seen = 1'b0;
      wait_fall(100, ok);
      runs++; if (!ok) begin fails++; $display("FAIL mid_trigger got no trigger fall want one"); end
      repeat (10) @(negedge clk);
      echo = 1'b1;
      repeat (300) begin
         @(negedge clk);
         if (valido === 1'b1) seen = 1'b1;
      end
      runs++; if (ocupado !== 1'b1) begin fails++; $display("FAIL mid_busy got %b want 1", ocupado); end
      rst_n = 1'b0;
      @(negedge clk);
      runs++; if ({trigger, valido, erro, ocupado} !== 4'b0000) begin fails++; $display("FAIL mid_reset_flags got %b want 0000", {trigger, valido, erro, ocupado}); end
      runs++; if (distancia_cm !== 8'd0) begin fails++; $display("FAIL mid_reset_dist got %0d want 0", distancia_cm); end
      repeat (2) begin
         @(negedge clk);
         if (valido === 1'b1) seen = 1'b1;
      end
      echo  = 1'b0;
      rst_n = 1'b1;
      runs++; if (seen) begin fails++; $display("FAIL mid_no_valido got 1 want 0"); end
   endtask

   task automatic test_echo_preheld;
      bit ok;
      int n;
      do_reset(1'b1);
      wait_fall(100, ok);
      runs++; if (!ok) begin fails++; $display("FAIL pre_trigger got no trigger pulse want one"); end
      repeat (100) @(negedge clk);
      echo = 1'b0;
      repeat (100) @(negedge clk);
      runs++; if ({valido, ocupado} !== 2'b01) begin fails++; $display("FAIL pre_still_waiting got %b want 01", {valido, ocupado}); end
      pulse(580 * TK);
      wait_valido(20, n);
      runs++; if (valido !== 1'b1) begin fails++; $display("FAIL pre_valido got %b want 1", valido); end
      runs++; if (distancia_cm !== exp_d(10)) begin fails++; $display("FAIL pre_dist got %0d want %0d", distancia_cm, exp_d(10)); end
      runs++; if (erro !== 1'b0) begin fails++; $display("FAIL pre_erro got %b want 0", erro); end
   endtask

`ifdef MEDIDOR_MEDIA_EN
   task automatic test_media;
      bit ok;
      int n;
      do_reset(1'b0);
      for (int k = 1; k <= 4; k++) begin
         wait_fall(40000, ok);
         repeat (10) @(negedge clk);
         pulse(1160 * TK);
         wait_valido(20, n);
         runs++; if (!ok || valido !== 1'b1 || distancia_cm !== 8'(5 * k)) begin fails++; $display("FAIL media_%0d got %0d want %0d", k, distancia_cm, 5 * k); end
      end
   endtask
`endif

   initial begin
      test_reset;
      test_distance(600, 10, "d600");
      test_distance(116, 2, "d116");
      test_distance(14900, 255, "sat");
      test_timeout;
      test_reset_mid_measure;
      test_echo_preheld;
`ifdef MEDIDOR_MEDIA_EN
      test_media;
`endif
      $display("[TB] %0d tests run, %0d failed", runs, fails);
      $finish;
   end
endmodule
